// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with memory-wait timeout
// Outputs are pure decode of the current state (plus zero/mem_ready where noted).
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem2reg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic       extop,
  output logic [1:0] pc_source,
  output logic [3:0] aluop,
  output logic       instr_done,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait;
  logic       w_mem_wait;
  logic       w_timeout;
  logic       w_rfunc_ok;
  logic [3:0] w_rfunc_aluop;

  always_comb begin
    w_rfunc_ok    = 1'b1;
    w_rfunc_aluop = 4'b1111;
    case (func)
      6'b100000: w_rfunc_aluop = 4'b0010;
      6'b100010: w_rfunc_aluop = 4'b0110;
      6'b100100: w_rfunc_aluop = 4'b0000;
      6'b100101: w_rfunc_aluop = 4'b0001;
      6'b101010: w_rfunc_aluop = 4'b0111;
      default:   w_rfunc_ok    = 1'b0;
    endcase
  end

  // mem_ready takes priority: a timeout only fires on a cycle that is still waiting
  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR)) && !mem_ready;
  assign w_timeout  = w_mem_wait && (r_wait == WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_rfunc_ok ? S_REXEC : S_ERR;
          OP_BEQ:       w_next = S_BRANCH;
          default:      w_next = S_ERR;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_REXEC:  w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_ERR;
    endcase
    if (w_timeout) w_next = S_ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= 8'd0;
      else if (w_mem_wait)   r_wait <= r_wait + 8'd1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem2reg    = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrc_a   = 1'b0;
    alusrc_b   = 2'b00;
    extop      = 1'b0;
    pc_source  = 2'b00;
    aluop      = 4'b1111;
    instr_done = 1'b0;
    err        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrc_b = 2'b01;
        aluop    = 4'b0010;
        // No PC/IR load may escape while reset is held
        ir_write = mem_ready & rst_n;
        pc_write = mem_ready & rst_n;
      end
      S_DECODE: begin
        alusrc_b = 2'b11;
        extop    = 1'b1;
        aluop    = 4'b0010;
      end
      S_MEMADR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        extop    = 1'b1;
        aluop    = 4'b0010;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        mem2reg    = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alusrc_a = 1'b1;
        aluop    = w_rfunc_aluop;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrc_a   = 1'b1;
        aluop      = 4'b0110;
        pc_source  = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  assign state = r_state;

endmodule
